// File: rtl/event_pulse_arb.sv
// event_pulse_arb: per-channel edge detector. Each detected edge becomes one
// PULSE_W-cycle pulse, and pulses are serialised one channel at a time in
// round-robin order.
// Ports: clk, rst (async, active-high), x[N] level inputs,
//   y[N] one-hot pulse, evt_valid = |y, evt_id = pulsing channel,
//   pending[N] = edges still waiting for their pulse.
// Optional macro EVT_SYNC_EN adds a 2-flop synchroniser on x.
module event_pulse_arb #(
  parameter int N       = 4,
  parameter int PULSE_W = 1,
  parameter int GAP     = 0,
  parameter int MODE    = 0,
  parameter int ID_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    x,
  output logic [N-1:0]    y,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N-1:0]    pending
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0]      PW_M1    = 8'(PULSE_W - 1);
  localparam logic [7:0]      GAP_M1   = 8'(GAP - 1);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    x_q;
  logic [N-1:0]    x_s;
  logic [N-1:0]    rise, fall, evt, req, grant;
  logic [ID_W-1:0] pick;

`ifdef EVT_SYNC_EN
  logic [N-1:0] s1_q, s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= x;
      s2_q <= s1_q;
    end
  end

  assign x_s = s2_q;
`else
  assign x_s = x;
`endif

  always_comb begin
    rise = x_s & ~x_q;
    fall = ~x_s & x_q;
    case (MODE)
      0:       evt = rise;
      1:       evt = fall;
      default: evt = rise | fall;
    endcase
  end

  assign req = pend_q | evt;

  // First set bit of r searching upward from l+1, wrapping.
  // Lower offsets overwrite higher ones, so the nearest wins.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [N-1:0]    r,
    input logic [ID_W-1:0] l
  );
    logic [ID_W-1:0] p;
    logic [N-1:0]    rs;
    int              j;
    p = l;
    for (int i = N; i >= 1; i--) begin
      j = int'(l) + i;
      if (j >= N) j = j - N;
      rs = r >> j;
      if (rs[0]) p = ID_W'(j);
    end
    return p;
  endfunction

  assign pick = rr_pick(req, last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    grant   = '0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant   = N'(1) << pick;
          id_d    = pick;
          last_d  = pick;
          cnt_d   = PW_M1;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == 8'd0) begin
          if (GAP > 0) begin
            cnt_d   = GAP_M1;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else cnt_d = cnt_q - 8'd1;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // An edge on the channel being granted re-arms its bit only
  // when it arrives after the grant cycle.
  assign pend_d = req & ~grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      id_q    <= '0;
      last_q  <= LAST_RST;
      pend_q  <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      x_q     <= x_s;
    end
  end

  assign y         = (state_q == S_PULSE) ? (N'(1) << id_q) : '0;
  assign evt_valid = |y;
  assign evt_id    = (state_q == S_PULSE) ? id_q : '0;
  assign pending   = pend_q;

endmodule

// File: tb/tb_event_pulse_arb.sv
// tb_event_pulse_arb: three configurations of event_pulse_arb checked
// against vector tables, hand sequences and a per-cycle behavioural model.
module tb_event_pulse_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x0, x1, x2;
  logic [3:0] y0, y1, y2, p0, p1, p2;
  logic       v0, v1, v2;
  logic [1:0] id0, id1, id2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  event_pulse_arb #(.N(4), .PULSE_W(1), .GAP(0), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .x(x0), .y(y0),
    .evt_valid(v0), .evt_id(id0), .pending(p0));

  event_pulse_arb #(.N(4), .PULSE_W(3), .GAP(2), .MODE(2)) u1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1),
    .evt_valid(v1), .evt_id(id1), .pending(p1));

  event_pulse_arb #(.N(4), .PULSE_W(5), .GAP(0), .MODE(1)) u2 (
    .clk(clk), .rst(rst), .x(x2), .y(y2),
    .evt_valid(v2), .evt_id(id2), .pending(p2));

  // Model: pl = pulse cycles left (incl. current), wl = forced low
  // cycles left before the idle cycle in which a grant may happen.
  typedef struct {
    logic [3:0] xp;
    logic [3:0] pend;
    int         last;
    int         pl;
    int         wl;
    int         id;
  } mdl_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] p;
    logic [1:0] id;
  } vec_t;

  mdl_t m0, m1, m2;
  vec_t tbl [10];

  function automatic mdl_t mreset();
    mdl_t s;
    s.xp = 4'b0; s.pend = 4'b0; s.last = 3;
    s.pl = 0; s.wl = 0; s.id = 0;
    return s;
  endfunction

  function automatic mdl_t step(mdl_t s, logic [3:0] x,
                                int pw, int gap, int mode);
    logic [3:0] r, f, e, rq;
    r  = x & ~s.xp;
    f  = ~x & s.xp;
    e  = (mode == 0) ? r : (mode == 1) ? f : (r | f);
    rq = s.pend | e;
    s.xp = x;
    if (s.pl > 0) begin
      s.pend = rq;
      s.pl--;
      if (s.pl == 0) s.wl = gap;
    end else if (s.wl > 0) begin
      s.pend = rq;
      s.wl--;
    end else if (rq != 4'b0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (s.last + k) % 4;
        if (rq[c]) begin
          s.id   = c;
          s.last = c;
          s.pl   = pw;
          s.pend = rq & ~(4'b1 << c);
          break;
        end
      end
    end else begin
      s.pend = rq;
    end
    return s;
  endfunction

  function automatic logic [3:0] my(mdl_t s);
    return (s.pl > 0) ? 4'(1 << s.id) : 4'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input logic [3:0] y,
                     input logic v, input logic [1:0] id,
                     input logic [3:0] p, input mdl_t m);
    chk({nm, ".y"}, 32'(y), 32'(my(m)));
    chk({nm, ".valid"}, 32'(v), 32'(my(m) != 4'b0));
    chk({nm, ".id"}, 32'(id), (m.pl > 0) ? 32'(m.id) : 32'd0);
    chk({nm, ".pend"}, 32'(p), 32'(m.pend));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m0 = mreset(); m1 = mreset(); m2 = mreset();
    end else begin
      m0 = step(m0, x0, 1, 0, 0);
      m1 = step(m1, x1, 3, 2, 2);
      m2 = step(m2, x2, 5, 0, 1);
    end
    #1;
    cmp("m0", y0, v0, id0, p0, m0);
    cmp("m1", y1, v1, id1, p1, m1);
    cmp("m2", y2, v2, id2, p2, m2);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int g [$];
    int pc;
    logic [3:0] e1y [10];
    logic [3:0] e1p [10];

    tbl[0] = '{x: 4'b0000, y: 4'b0000, p: 4'b0000, id: 2'd0};
    tbl[1] = '{x: 4'b1001, y: 4'b0001, p: 4'b1000, id: 2'd0};
    tbl[2] = '{x: 4'b1001, y: 4'b0000, p: 4'b1000, id: 2'd0};
    tbl[3] = '{x: 4'b1001, y: 4'b1000, p: 4'b0000, id: 2'd3};
    tbl[4] = '{x: 4'b1001, y: 4'b0000, p: 4'b0000, id: 2'd0};
    tbl[5] = '{x: 4'b1101, y: 4'b0100, p: 4'b0000, id: 2'd2};
    tbl[6] = '{x: 4'b1101, y: 4'b0000, p: 4'b0000, id: 2'd0};
    tbl[7] = '{x: 4'b1101, y: 4'b0000, p: 4'b0000, id: 2'd0};
    tbl[8] = '{x: 4'b1101, y: 4'b0000, p: 4'b0000, id: 2'd0};
    tbl[9] = '{x: 4'b1101, y: 4'b0000, p: 4'b0000, id: 2'd0};

    e1y = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
    e1p = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};

    rst = 1'b1;
    x0 = 4'b0; x1 = 4'b0; x2 = 4'hF;
    m0 = mreset(); m1 = mreset(); m2 = mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", 32'(y0), 0);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_id", 32'(id0), 0);
    chk("rst_pend", 32'(p0), 0);
    @(negedge clk) rst = 1'b0;

    // Simultaneous rise on 0 and 3, then single rise on 2.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) x0 = tbl[i].x;
      tick();
      chk("tbl_y", 32'(y0), 32'(tbl[i].y));
      chk("tbl_id", 32'(id0), 32'(tbl[i].id));
      chk("tbl_valid", 32'(v0), 32'(tbl[i].y != 4'b0));
      chk("tbl_pend", 32'(p0), 32'(tbl[i].p));
      chk("mode1_nopulse", 32'(y2), 0);
    end

    // Held high: no further pulses.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_y", 32'(y0), 0);
    end

    // Round-robin: channels 1 and 2 keep retriggering.
    @(negedge clk) x0 = 4'b0000;
    tick();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk) x0 = (i % 2 == 0) ? 4'b0110 : 4'b0000;
      tick();
      if (v0) g.push_back(int'(id0));
    end
    chk("rr_count", 32'(g.size() >= 6), 1);
    if (g.size() > 0) chk("rr_first", 32'(g[0]), 1);
    for (int i = 1; i < g.size(); i++)
      chk("rr_alt", 32'(g[i]), (g[i-1] == 1) ? 32'd2 : 32'd1);
    @(negedge clk) x0 = 4'b0000;
    for (int i = 0; i < 20 && p0 != 4'b0; i++) tick();
    chk("rr_drain", 32'(p0), 0);

    // PULSE_W=3, GAP=2, both edges: retrigger during pulse.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) x1 = 4'b0010;
      if (i == 1) x1 = 4'b0000;
      tick();
      chk("retrig_y", 32'(y1), 32'(e1y[i]));
      chk("retrig_pend", 32'(p1), 32'(e1p[i]));
    end
    pc = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) x1 = 4'b0010;
      if (i == 10) x1 = 4'b0000;
      tick();
      if (y1 == 4'b0010 && id1 == 2'd1) pc++;
    end
    chk("two_pulses_cycles", 32'(pc), 6);

    // Falling mode, then reset in the 2nd pulse cycle.
    @(negedge clk) x2 = 4'b0111;
    tick();
    chk("fall_y", 32'(y2), 32'h8);
    @(negedge clk) x2 = 4'b0101;
    tick();
    chk("fall2_y", 32'(y2), 32'h8);
    chk("fall2_pend", 32'(p2), 32'h2);
    #1 rst = 1'b1;
    #1;
    chk("arst_y", 32'(y2), 0);
    chk("arst_pend", 32'(p2), 0);
    chk("arst_id", 32'(id2), 0);
    chk("arst_valid", 32'(v2), 0);
    @(negedge clk) begin
      x0 = 4'b0; x1 = 4'b0; x2 = 4'b0;
    end
    tick();
    tick();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_y", 32'(y2), 0);
    end

    // Random traffic against the model, with one reset mid-run.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rst = (i == 250);
      x0 ^= 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      x1 ^= 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      x2 ^= 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
